// File: rtl/data_memory_if.sv
// Request/response bus between the MEM stage and data_memory.
// The master holds a request until ready_o; responses are one-cycle rvalid_o pulses.
interface data_memory_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic                  req_i;
  logic                  we_i;
  logic [DATA_W/8-1:0]   be_i;
  logic [ADDR_W-1:0]     addr_i;
  logic [DATA_W-1:0]     wdata_i;
  logic                  ready_o;
  logic                  rvalid_o;
  logic [DATA_W-1:0]     rdata_o;
  logic                  err_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  ready_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output ready_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/data_memory.sv
// Byte-enabled data memory; response pulse LATENCY cycles after accept, one access in flight.
// ready_o is high only in IDLE, so requests stall (no queueing) while an access is pending.
module data_memory #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  data_memory_if.slave  bus
);

  localparam int NB = DATA_W / 8;
  localparam int BW = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << BW) - 1);
  localparam logic [ADDR_W:0]   MEM_BYTES  = (ADDR_W + 1)'(DEPTH * NB);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [NB-1:0]     be_q, be_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_err_q, req_err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [IW-1:0]     in_idx;
  logic              in_err;
  logic              use_in;
  logic              op_we;
  logic [NB-1:0]     op_be;
  logic [IW-1:0]     op_idx;
  logic [DATA_W-1:0] op_wdata;
  logic              op_err;
  logic              enter_resp;
  logic              mem_wr;
  logic              ready;
  logic              rvalid;

  assign in_idx = bus.addr_i[BW +: IW];
  assign in_err = ((bus.addr_i & ALIGN_MASK) != '0) ||
                  ({1'b0, bus.addr_i} >= MEM_BYTES);

  // With LATENCY=1 RESP is entered on the accept edge itself, so the
  // operation must come straight from the bus rather than the latches.
  assign use_in   = (state_q == ST_IDLE);
  assign op_we    = use_in ? bus.we_i    : we_q;
  assign op_be    = use_in ? bus.be_i    : be_q;
  assign op_idx   = use_in ? in_idx      : idx_q;
  assign op_wdata = use_in ? bus.wdata_i : wdata_q;
  assign op_err   = use_in ? in_err      : req_err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    be_d      = be_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    req_err_d = req_err_q;
    ready     = 1'b0;
    rvalid    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.req_i) begin
          we_d      = bus.we_i;
          be_d      = bus.be_i;
          idx_d     = in_idx;
          wdata_d   = bus.wdata_i;
          req_err_d = in_err;
          if (LATENCY > 1) begin
            state_d = ST_WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rvalid  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

  always_comb begin
    rdata_d   = rdata_q;
    rsp_err_d = rsp_err_q;
    mem_wr    = 1'b0;
    if (enter_resp) begin
      rsp_err_d = op_err;
      rdata_d   = (op_we || op_err) ? '0 : mem_q[op_idx];
      mem_wr    = op_we && !op_err && rst_ni;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      req_err_q <= 1'b0;
      rdata_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      be_q      <= be_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      req_err_q <= req_err_d;
      rdata_q   <= rdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Storage is deliberately left out of reset; contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (mem_wr) begin
      for (int k = 0; k < NB; k++) begin
        if (op_be[k]) begin
          mem_q[op_idx][8*k +: 8] <= op_wdata[8*k +: 8];
        end
      end
    end
  end

  assign bus.ready_o  = ready;
  assign bus.rvalid_o = rvalid;
  assign bus.rdata_o  = rdata_q;
  assign bus.err_o    = rsp_err_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: LATENCY=2 functional instance plus LATENCY=1/4 throughput instances.
module tb_data_memory;

  logic clk;
  logic rst_n;

  data_memory_if #(.DATA_W(32), .ADDR_W(32)) m_if ();
  data_memory_if #(.DATA_W(32), .ADDR_W(32)) l1_if ();
  data_memory_if #(.DATA_W(32), .ADDR_W(32)) l4_if ();

  data_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(2)) u_dut (
    .clk_i (clk), .rst_ni (rst_n), .bus (m_if.slave)
  );
  data_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(1)) u_dut_l1 (
    .clk_i (clk), .rst_ni (rst_n), .bus (l1_if.slave)
  );
  data_memory #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .LATENCY(4)) u_dut_l4 (
    .clk_i (clk), .rst_ni (rst_n), .bus (l4_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] r_dat;
  logic        r_err;
  int          r_lat;
  int          r_rdy_low;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // One access on the LATENCY=2 instance. r_lat counts edges from the accept
  // edge to the edge that samples rvalid_o; 0 means no response arrived.
  task automatic access(input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!m_if.ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    m_if.req_i   = 1'b1;
    m_if.we_i    = w;
    m_if.be_i    = b;
    m_if.addr_i  = a;
    m_if.wdata_i = d;
    @(posedge clk);
    #1;
    m_if.req_i = 1'b0;
    r_lat     = 0;
    r_rdy_low = 0;
    r_dat     = 32'hDEAD_DEAD;
    r_err     = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!m_if.ready_o) r_rdy_low++;
      if (m_if.rvalid_o) begin
        r_lat = c;
        r_dat = m_if.rdata_o;
        r_err = m_if.err_o;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_rv;
  int acc1[$];
  int acc4[$];
  int rv1;
  int rv4;

  initial begin
    m_if.req_i = 1'b0;  m_if.we_i = 1'b0;  m_if.be_i = '0;  m_if.addr_i = '0;  m_if.wdata_i = '0;
    l1_if.req_i = 1'b0; l1_if.we_i = 1'b0; l1_if.be_i = '0; l1_if.addr_i = '0; l1_if.wdata_i = '0;
    l4_if.req_i = 1'b0; l4_if.we_i = 1'b0; l4_if.be_i = '0; l4_if.addr_i = '0; l4_if.wdata_i = '0;
    rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready",  32'(m_if.ready_o),  32'd1);
    check("rst_rvalid", 32'(m_if.rvalid_o), 32'd0);
    check("rst_rdata",  m_if.rdata_o,       32'h0);
    check("rst_err",    32'(m_if.err_o),    32'd0);
    rst_n = 1'b1;

    // Write then read-after-write, LATENCY=2
    access(1'b1, 4'hF, 32'h28, 32'hBEFF_EBEF);
    check("wr28_lat",     32'(r_lat),     32'd2);
    check("wr28_rdylow",  32'(r_rdy_low), 32'd2);
    check("wr28_err",     32'(r_err),     32'd0);
    check("wr28_rdata",   r_dat,          32'h0);
    @(negedge clk);
    check("wr28_onepulse", 32'(m_if.rvalid_o), 32'd0);
    check("wr28_ready",    32'(m_if.ready_o),  32'd1);

    access(1'b0, 4'h0, 32'h28, 32'h0);
    check("rd28_lat",    32'(r_lat),     32'd2);
    check("rd28_rdylow", 32'(r_rdy_low), 32'd2);
    check("rd28_data",   r_dat,          32'hBEFF_EBEF);
    check("rd28_err",    32'(r_err),     32'd0);
    @(negedge clk);
    check("rd28_hold", m_if.rdata_o, 32'hBEFF_EBEF);

    // Byte enables
    access(1'b1, 4'hF, 32'h30, 32'h0000_0000);
    access(1'b1, 4'b0101, 32'h30, 32'h1122_3344);
    check("be_wr_err", 32'(r_err), 32'd0);
    access(1'b0, 4'h0, 32'h30, 32'h0);
    check("be_rd30", r_dat, 32'h0022_0044);

    // be=0 write is a legal no-op
    access(1'b1, 4'h0, 32'h28, 32'hFFFF_FFFF);
    check("be0_lat", 32'(r_lat), 32'd2);
    check("be0_err", 32'(r_err), 32'd0);
    access(1'b0, 4'h0, 32'h28, 32'h0);
    check("be0_rd28", r_dat, 32'hBEFF_EBEF);

    // Misaligned read
    access(1'b0, 4'h0, 32'h29, 32'h0);
    check("mis_rd_err",   32'(r_err), 32'd1);
    check("mis_rd_rdata", r_dat,      32'h0);

    // Last valid word and out-of-range write that would alias word 0
    access(1'b1, 4'hF, 32'h00, 32'hCAFE_F00D);
    access(1'b1, 4'hF, 32'hFC, 32'h1234_5678);
    check("last_wr_err", 32'(r_err), 32'd0);
    access(1'b0, 4'h0, 32'hFC, 32'h0);
    check("last_rd_data", r_dat,      32'h1234_5678);
    check("last_rd_err",  32'(r_err), 32'd0);
    access(1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
    check("oor_wr_err",   32'(r_err), 32'd1);
    check("oor_wr_rdata", r_dat,      32'h0);
    access(1'b0, 4'h0, 32'h100, 32'h0);
    check("oor_rd_err",   32'(r_err), 32'd1);
    access(1'b0, 4'h0, 32'h00, 32'h0);
    check("oor_keep00", r_dat, 32'hCAFE_F00D);
    access(1'b0, 4'h0, 32'h28, 32'h0);
    check("oor_keep28", r_dat, 32'hBEFF_EBEF);
    access(1'b0, 4'h0, 32'h30, 32'h0);
    check("oor_keep30", r_dat, 32'h0022_0044);
    access(1'b0, 4'h0, 32'hFC, 32'h0);
    check("oor_keepFC", r_dat, 32'h1234_5678);

    // Reset while a write is waiting
    access(1'b1, 4'hF, 32'h08, 32'h0000_00AA);
    @(negedge clk);
    m_if.req_i = 1'b1; m_if.we_i = 1'b1; m_if.be_i = 4'hF;
    m_if.addr_i = 32'h08; m_if.wdata_i = 32'h0000_0055;
    @(posedge clk);
    #1;
    m_if.req_i = 1'b0;
    @(negedge clk);
    check("midrst_in_wait", 32'(m_if.ready_o), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_ready_async", 32'(m_if.ready_o), 32'd1);
    n_rv = 0;
    @(negedge clk);
    if (m_if.rvalid_o) n_rv++;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (m_if.rvalid_o) n_rv++;
    end
    check("midrst_no_resp", 32'(n_rv), 32'd0);
    access(1'b0, 4'h0, 32'h08, 32'h0);
    check("midrst_rd08", r_dat, 32'h0000_00AA);

    // Held req_i on LATENCY=1 and LATENCY=4 instances (misaligned reads -> err pulses)
    @(negedge clk);
    l1_if.req_i = 1'b1; l1_if.we_i = 1'b0; l1_if.addr_i = 32'h2;
    l4_if.req_i = 1'b1; l4_if.we_i = 1'b0; l4_if.addr_i = 32'h2;
    rv1 = 0;
    rv4 = 0;
    for (int c = 0; c < 20; c++) begin
      if (l1_if.ready_o && l1_if.req_i) acc1.push_back(c);
      if (l4_if.ready_o && l4_if.req_i) acc4.push_back(c);
      if (l1_if.rvalid_o && l1_if.err_o) rv1++;
      if (l4_if.rvalid_o && l4_if.err_o) rv4++;
      @(negedge clk);
    end
    l1_if.req_i = 1'b0;
    l4_if.req_i = 1'b0;
    repeat (8) begin
      if (l1_if.rvalid_o && l1_if.err_o) rv1++;
      if (l4_if.rvalid_o && l4_if.err_o) rv4++;
      @(negedge clk);
    end
    check("l1_accepts", 32'(acc1.size()), 32'd10);
    check("l4_accepts", 32'(acc4.size()), 32'd4);
    if (acc1.size() >= 3) begin
      check("l1_gap0", 32'(acc1[1] - acc1[0]), 32'd2);
      check("l1_gap1", 32'(acc1[2] - acc1[1]), 32'd2);
    end else begin
      check("l1_gap_avail", 32'(acc1.size()), 32'd10);
    end
    if (acc4.size() >= 3) begin
      check("l4_gap0", 32'(acc4[1] - acc4[0]), 32'd5);
      check("l4_gap1", 32'(acc4[2] - acc4[1]), 32'd5);
    end else begin
      check("l4_gap_avail", 32'(acc4.size()), 32'd4);
    end
    check("l1_pulses", 32'(rv1), 32'(acc1.size()));
    check("l4_pulses", 32'(rv4), 32'(acc4.size()));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
